// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ============================================================================
// uart_cmd_pkg -- frame constants and FSM encoding for uart_cmd_parser.
// Rev 1.0
// ============================================================================
package uart_cmd_pkg;

  localparam logic [7:0]  C_HEADER     = 8'hA5;
  localparam logic [7:0]  C_ACK        = 8'h06;
  localparam logic [7:0]  C_NAK        = 8'h15;
  localparam int unsigned C_FRAME_LEN  = 7;
  // header, addr and chk surround the big-endian data word
  localparam int unsigned C_DATA_BYTES = C_FRAME_LEN - 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2,
    ST_CHK   = 3'd3,
    ST_WRITE = 3'd4,
    ST_ACK   = 3'd5
  } state_t;

  function automatic logic in_frame(input state_t s);
    return (s == ST_ADDR) || (s == ST_DATA) || (s == ST_CHK);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_cmd_parser.sv
`default_nettype none
// ============================================================================
// uart_cmd_parser -- parses A5/addr/d3..d0/chk frames into register writes.
// Optional ACK/NAK reply enabled by macro UART_CMD_ACK_EN.  Rev 1.0
// ============================================================================
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int unsigned clock_freq  = 100_000_000,
  parameter int unsigned timeout_cyc = clock_freq / 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_rec_flag,
  output logic        rx_clr,
  output logic [7:0]  reg_addr,
  output logic [31:0] reg_data,
  output logic        reg_wr,
  output logic        frame_err,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_idle,
  input  logic        tx_done
);

  localparam int unsigned      TMO_W     = $clog2(timeout_cyc + 1);
  localparam logic [TMO_W-1:0] C_TMO_MAX = TMO_W'(timeout_cyc);

  state_t            state_q, state_d;
  logic [2:0]        byte_cnt_q, byte_cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [7:0]        chk_q, chk_d;
  logic [7:0]        addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [7:0]        reg_addr_q, reg_addr_d;
  logic [31:0]       reg_data_q, reg_data_d;
  logic              reg_wr_q, reg_wr_d;
  logic              frame_err_q, frame_err_d;
  logic              rx_clr_q, rx_clr_d;
  logic              clr_wait_q, clr_wait_d;
  logic              take_byte;

`ifdef UART_CMD_ACK_EN
  logic              nak_q, nak_d;
  logic              sent_q, sent_d;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        tx_data_q, tx_data_d;
`endif

  // The cycle of the rx_clr pulse and the one after it are blind, so a flag
  // the receiver has not yet dropped is never consumed twice.
  assign take_byte = rx_rec_flag && !rx_clr_q && !clr_wait_q &&
                     ((state_q == ST_IDLE) || in_frame(state_q));

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    tmo_d       = '0;
    chk_d       = chk_q;
    addr_d      = addr_q;
    data_d      = data_q;
    reg_addr_d  = reg_addr_q;
    reg_data_d  = reg_data_q;
    reg_wr_d    = 1'b0;
    frame_err_d = 1'b0;
    rx_clr_d    = take_byte;
    clr_wait_d  = rx_clr_q;
`ifdef UART_CMD_ACK_EN
    nak_d       = nak_q;
    sent_d      = sent_q;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (take_byte && (rx_data == C_HEADER)) begin
          state_d    = ST_ADDR;
          byte_cnt_d = '0;
          chk_d      = '0;
        end
      end
      ST_ADDR: begin
        if (take_byte) begin
          addr_d     = rx_data;
          chk_d      = rx_data;
          byte_cnt_d = '0;
          state_d    = ST_DATA;
        end
      end
      ST_DATA: begin
        if (take_byte) begin
          data_d     = {data_q[23:0], rx_data};
          chk_d      = chk_q ^ rx_data;
          byte_cnt_d = byte_cnt_q + 3'd1;
          if (byte_cnt_q == 3'(C_DATA_BYTES - 1)) begin
            state_d = ST_CHK;
          end
        end
      end
      ST_CHK: begin
        if (take_byte) begin
          if (rx_data == chk_q) begin
            state_d = ST_WRITE;
          end else begin
            frame_err_d = 1'b1;
`ifdef UART_CMD_ACK_EN
            nak_d   = 1'b1;
            sent_d  = 1'b0;
            state_d = ST_ACK;
`else
            state_d = ST_IDLE;
`endif
          end
        end
      end
      ST_WRITE: begin
        reg_wr_d   = 1'b1;
        reg_addr_d = addr_q;
        reg_data_d = data_q;
`ifdef UART_CMD_ACK_EN
        nak_d   = 1'b0;
        sent_d  = 1'b0;
        state_d = ST_ACK;
`else
        state_d = ST_IDLE;
`endif
      end
`ifdef UART_CMD_ACK_EN
      ST_ACK: begin
        if (!sent_q && tx_idle) begin
          tx_start_d = 1'b1;
          tx_data_d  = nak_q ? C_NAK : C_ACK;
          sent_d     = 1'b1;
        end else if (sent_q && tx_done) begin
          state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // Timeout drops the partial frame silently (no reply is ever sent).
    if (in_frame(state_q) && !take_byte) begin
      if (tmo_q == C_TMO_MAX) begin
        frame_err_d = 1'b1;
        state_d     = ST_IDLE;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      byte_cnt_q  <= '0;
      tmo_q       <= '0;
      chk_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      reg_addr_q  <= '0;
      reg_data_q  <= '0;
      reg_wr_q    <= 1'b0;
      frame_err_q <= 1'b0;
      rx_clr_q    <= 1'b0;
      clr_wait_q  <= 1'b0;
`ifdef UART_CMD_ACK_EN
      nak_q       <= 1'b0;
      sent_q      <= 1'b0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      tmo_q       <= tmo_d;
      chk_q       <= chk_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      reg_addr_q  <= reg_addr_d;
      reg_data_q  <= reg_data_d;
      reg_wr_q    <= reg_wr_d;
      frame_err_q <= frame_err_d;
      rx_clr_q    <= rx_clr_d;
      clr_wait_q  <= clr_wait_d;
`ifdef UART_CMD_ACK_EN
      nak_q       <= nak_d;
      sent_q      <= sent_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
`endif
    end
  end

  assign rx_clr    = rx_clr_q;
  assign reg_addr  = reg_addr_q;
  assign reg_data  = reg_data_q;
  assign reg_wr    = reg_wr_q;
  assign frame_err = frame_err_q;

`ifdef UART_CMD_ACK_EN
  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
`else
  logic unused_tx;
  assign unused_tx = tx_idle | tx_done;
  assign tx_start  = 1'b0;
  assign tx_data   = 8'h00;
`endif

endmodule
`default_nettype wire
